toy_lsu_mem_bridge: RTL and testbench

Load/store bridge between the core's LSU request channel and the single-port word-addressed data memory port (en/addr/rd_data/wr_data/wr_byte_en/wr_en, 1-cycle registered read). It accepts byte/half/word requests on a valid/ready channel, checks alignment, and generates the word address, replicated write data and byte enables. It captures and extends load data one cycle after issue and returns one response per request on a valid/ready channel. One request is in flight at a time.

---
 rtl/toy_lsu_pkg.sv | 30 +++
 rtl/toy_lsu_mem_bridge_align.sv | 52 +++++
 rtl/toy_lsu_mem_bridge.sv | 125 ++++++++++++
 tb/tb_toy_lsu_mem_bridge.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/toy_lsu_pkg.sv
// Shared types and helpers for the LSU-to-memory bridge.
//   size_e  : request access size encoding (3 is illegal, not an enum member)
//   state_e : bridge control states
//   align_err() : flags illegal size or an address not aligned to the size
package toy_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        LD_WAIT,
        RESP
    } state_e;

    function automatic logic align_err(input logic [1:0] size, input logic [1:0] off);
        logic err;
        case (size)
            SZ_B:    err = 1'b0;
            SZ_H:    err = off[0];
            SZ_W:    err = (off != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/toy_lsu_mem_bridge_align.sv
// Combinational lane logic for a 32-bit, 4-lane memory word.
// Ports:
//   st_size/st_off/st_wdata  -> st_byte_en/st_data : store enables and lane-replicated data
//   ld_size/ld_off/ld_unsigned/ld_rdata -> ld_data : selected load lane, zero/sign extended
module toy_lsu_align
    import toy_lsu_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_byte_en,
    output logic [31:0] st_data,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;

    // Replicating the data into every lane lets the byte enables alone pick the target lane.
    always_comb begin
        st_byte_en = 4'b0000;
        st_data    = st_wdata;
        case (st_size)
            SZ_B: begin
                st_byte_en = 4'b0001 << st_off;
                st_data    = {4{st_wdata[7:0]}};
            end
            SZ_H: begin
                st_byte_en = 4'b0011 << st_off;
                st_data    = {2{st_wdata[15:0]}};
            end
            SZ_W:    st_byte_en = 4'b1111;
            default: st_byte_en = 4'b0000;
        endcase
    end

    always_comb begin
        lane_b  = ld_rdata[{ld_off, 3'b000} +: 8];
        lane_h  = ld_rdata[{ld_off[1], 4'b0000} +: 16];
        ld_data = ld_rdata;
        case (ld_size)
            SZ_B:    ld_data = ld_unsigned ? {24'b0, lane_b} : 32'(lane_b);
            SZ_H:    ld_data = ld_unsigned ? {16'b0, lane_h} : 32'(lane_h);
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/toy_lsu_mem_bridge.sv
// Load/store bridge from the LSU valid/ready request channel to a single-port
// word-addressed memory with 1-cycle registered read. One request in flight.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   req_*               : request channel (byte address, store flag, size, unsigned, store data)
//   resp_*              : response channel (extended load data, alignment/size error)
//   mem_*               : memory port; driven only during an accepted, legal request in IDLE
module toy_lsu_mem_bridge
    import toy_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_vld,
    output logic                    req_rdy,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    req_wr,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_vld,
    input  logic                    resp_rdy,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic                    mem_en,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_rd_data,
    output logic [DATA_WIDTH-1:0]   mem_wr_data,
    output logic [DATA_WIDTH/8-1:0] mem_wr_byte_en,
    output logic                    mem_wr_en
);

    state_e                  state, next_state;
    logic                    accept;
    logic                    req_err;
    logic [DATA_WIDTH/8-1:0] st_be;
    logic [DATA_WIDTH-1:0]   st_data;
    logic [DATA_WIDTH-1:0]   ld_data;
    logic [1:0]              ld_off_p1;
    logic [1:0]              ld_size_p1;
    logic                    ld_unsigned_p1;

    assign req_rdy  = (state == IDLE);
    assign resp_vld = (state == RESP);
    // rst gates the handshake so the memory port stays quiet while reset is held.
    assign accept   = req_vld && (state == IDLE) && !rst;
    assign req_err  = align_err(req_size, req_addr[1:0]);

    toy_lsu_align u_align (
        .st_size     (req_size),
        .st_off      (req_addr[1:0]),
        .st_wdata    (req_wdata),
        .st_byte_en  (st_be),
        .st_data     (st_data),
        .ld_size     (ld_size_p1),
        .ld_off      (ld_off_p1),
        .ld_unsigned (ld_unsigned_p1),
        .ld_rdata    (mem_rd_data),
        .ld_data     (ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state     = state;
        mem_en         = 1'b0;
        mem_wr_en      = 1'b0;
        mem_addr       = '0;
        mem_wr_data    = '0;
        mem_wr_byte_en = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        next_state = RESP;
                    end else begin
                        mem_en   = 1'b1;
                        mem_addr = {2'b00, req_addr[ADDR_WIDTH-1:2]};
                        if (req_wr) begin
                            mem_wr_en      = 1'b1;
                            mem_wr_data    = st_data;
                            mem_wr_byte_en = st_be;
                            next_state     = RESP;
                        end else begin
                            next_state = LD_WAIT;
                        end
                    end
                end
            end
            LD_WAIT: next_state = RESP;
            RESP:    if (resp_rdy) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Stage 1 boundary: load attributes held for lane extraction in LD_WAIT.
    always_ff @(posedge clk) begin
        if (accept && !req_wr) begin
            ld_off_p1      <= req_addr[1:0];
            ld_size_p1     <= req_size;
            ld_unsigned_p1 <= req_unsigned;
        end
    end

    // Response registers: cleared on accept (stores/errors carry zero data),
    // then loaded with extended read data in LD_WAIT; untouched while in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (accept) begin
            resp_rdata <= '0;
            resp_err   <= req_err;
        end else if (state == LD_WAIT) begin
            resp_rdata <= ld_data;
        end
    end

endmodule

// File: tb/tb_toy_lsu_mem_bridge.sv
// Self-checking bench for toy_lsu_mem_bridge: table of requests with expected
// memory-port and response values, a scoreboard queue for responses, and
// hand-written backpressure and mid-load reset sequences.
module tb_toy_lsu_mem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_vld, req_rdy, req_wr, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_vld, resp_rdy, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_en, mem_wr_en;
    logic [31:0] mem_addr, mem_rd_data, mem_wr_data;
    logic [3:0]  mem_wr_byte_en;

    toy_lsu_mem_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_vld        (req_vld),
        .req_rdy        (req_rdy),
        .req_addr       (req_addr),
        .req_wr         (req_wr),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_wdata      (req_wdata),
        .resp_vld       (resp_vld),
        .resp_rdy       (resp_rdy),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_en         (mem_en),
        .mem_addr       (mem_addr),
        .mem_rd_data    (mem_rd_data),
        .mem_wr_data    (mem_wr_data),
        .mem_wr_byte_en (mem_wr_byte_en),
        .mem_wr_en      (mem_wr_en)
    );

    always #5 clk = ~clk;

    // Memory model: byte-enabled write, 1-cycle registered read.
    logic [31:0] mem_model [0:63];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wr_en) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wr_byte_en[b]) mem_model[mem_addr[5:0]][8*b +: 8] <= mem_wr_data[8*b +: 8];
            end
            mem_rd_data <= mem_model[mem_addr[5:0]];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          t;
        int          lat;   // 0 = latency not checked
    } exp_t;
    exp_t sb[$];

    // Response monitor: pops one expectation per response handshake.
    always @(negedge clk) begin
        if (!rst && resp_vld && resp_rdy) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_resp: got rdata %h err %b with no request outstanding", resp_rdata, resp_err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_err", resp_err, e.err);
                if (e.lat != 0) check("resp_latency", cyc - e.t, e.lat);
            end
        end
    end

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic        men;
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic issue(input int idx, input vec_t v);
        int n = 0;
        while (!req_rdy && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check($sformatf("v%0d_req_rdy", idx), req_rdy, 1);
        req_vld = 1'b1; req_addr = v.addr; req_wr = v.wr;
        req_size = v.size; req_unsigned = v.uns; req_wdata = v.wdata;
        @(negedge clk);
        check($sformatf("v%0d_mem_en", idx), mem_en, v.men);
        check($sformatf("v%0d_mem_wr_en", idx), mem_wr_en, v.men & v.wr);
        check($sformatf("v%0d_mem_addr", idx), mem_addr, v.maddr);
        check($sformatf("v%0d_byte_en", idx), mem_wr_byte_en, v.be);
        check($sformatf("v%0d_mem_wr_data", idx), mem_wr_data, v.mwdata);
        sb.push_back('{v.rdata, v.err, cyc, v.lat});
        @(posedge clk); #1;
        req_vld = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_mem_en_after", idx), {mem_en, mem_wr_en}, 2'b00);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; req_vld = 1'b0; req_addr = '0; req_wr = 1'b0;
        req_size = 2'd0; req_unsigned = 1'b0; req_wdata = '0; resp_rdy = 1'b1;

        //          addr      wr    size  uns   wdata         men   maddr  be     mwdata        rdata         err   lat
        vecs[0]  = '{32'h10, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 1'b1, 32'h4, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0, 1};
        vecs[1]  = '{32'h13, 1'b1, 2'd0, 1'b0, 32'h000000A5, 1'b1, 32'h4, 4'h8, 32'hA5A5A5A5, 32'h0,        1'b0, 1};
        vecs[2]  = '{32'h10, 1'b0, 2'd2, 1'b0, 32'h0,        1'b1, 32'h4, 4'h0, 32'h0,        32'hA5ADBEEF, 1'b0, 2};
        vecs[3]  = '{32'h10, 1'b1, 2'd2, 1'b0, 32'h80017F80, 1'b1, 32'h4, 4'hF, 32'h80017F80, 32'h0,        1'b0, 1};
        vecs[4]  = '{32'h12, 1'b0, 2'd0, 1'b0, 32'h0,        1'b1, 32'h4, 4'h0, 32'h0,        32'h00000001, 1'b0, 2};
        vecs[5]  = '{32'h12, 1'b0, 2'd1, 1'b0, 32'h0,        1'b1, 32'h4, 4'h0, 32'h0,        32'hFFFF8001, 1'b0, 2};
        vecs[6]  = '{32'h12, 1'b0, 2'd1, 1'b1, 32'h0,        1'b1, 32'h4, 4'h0, 32'h0,        32'h00008001, 1'b0, 2};
        vecs[7]  = '{32'h10, 1'b0, 2'd0, 1'b0, 32'h0,        1'b1, 32'h4, 4'h0, 32'h0,        32'hFFFFFF80, 1'b0, 2};
        vecs[8]  = '{32'h11, 1'b0, 2'd0, 1'b1, 32'h0,        1'b1, 32'h4, 4'h0, 32'h0,        32'h0000007F, 1'b0, 2};
        vecs[9]  = '{32'h16, 1'b1, 2'd1, 1'b0, 32'hABCD1234, 1'b1, 32'h5, 4'hC, 32'h12341234, 32'h0,        1'b0, 1};
        vecs[10] = '{32'h17, 1'b0, 2'd0, 1'b1, 32'h0,        1'b1, 32'h5, 4'h0, 32'h0,        32'h00000012, 1'b0, 2};
        vecs[11] = '{32'h16, 1'b0, 2'd1, 1'b0, 32'h0,        1'b1, 32'h5, 4'h0, 32'h0,        32'h00001234, 1'b0, 2};
        vecs[12] = '{32'h21, 1'b1, 2'd0, 1'b0, 32'hFFFFFF3C, 1'b1, 32'h8, 4'h2, 32'h3C3C3C3C, 32'h0,        1'b0, 1};
        vecs[13] = '{32'h21, 1'b0, 2'd0, 1'b1, 32'h0,        1'b1, 32'h8, 4'h0, 32'h0,        32'h0000003C, 1'b0, 2};
        vecs[14] = '{32'h11, 1'b0, 2'd1, 1'b0, 32'h0,        1'b0, 32'h0, 4'h0, 32'h0,        32'h0,        1'b1, 1};
        vecs[15] = '{32'h16, 1'b1, 2'd2, 1'b0, 32'h11111111, 1'b0, 32'h0, 4'h0, 32'h0,        32'h0,        1'b1, 1};
        vecs[16] = '{32'h10, 1'b0, 2'd3, 1'b0, 32'h0,        1'b0, 32'h0, 4'h0, 32'h0,        32'h0,        1'b1, 1};

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_rdy", req_rdy, 1);
        check("rst_resp_vld", resp_vld, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_mem_en", {mem_en, mem_wr_en}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) issue(i, vecs[i]);

        // Backpressure: load response held for 5 cycles with a store pending.
        resp_rdy = 1'b0;
        issue(100, '{32'h10, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, 32'h4, 4'h0, 32'h0, 32'h80017F80, 1'b0, 0});
        req_vld = 1'b1; req_wr = 1'b1; req_size = 2'd2; req_addr = 32'h18; req_wdata = 32'hCAFEF00D;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_resp_vld", resp_vld, 1);
            check("bp_resp_rdata", resp_rdata, 32'h80017F80);
            check("bp_req_rdy", req_rdy, 0);
            check("bp_mem_en", mem_en, 0);
        end
        @(posedge clk); #1;
        resp_rdy = 1'b1;
        @(negedge clk);
        check("bp_hs_req_rdy", req_rdy, 0);
        check("bp_hs_mem_en", mem_en, 0);
        @(negedge clk);
        check("bp_next_req_rdy", req_rdy, 1);
        check("bp_next_mem_en", mem_en, 1);
        check("bp_next_mem_wr_en", mem_wr_en, 1);
        check("bp_next_mem_addr", mem_addr, 32'h6);
        check("bp_next_byte_en", mem_wr_byte_en, 4'hF);
        check("bp_next_wr_data", mem_wr_data, 32'hCAFEF00D);
        sb.push_back('{32'h0, 1'b0, cyc, 1});
        @(posedge clk); #1;
        req_vld = 1'b0;
        @(posedge clk); #1;

        // Reset while a load waits for read data: the load is dropped.
        req_vld = 1'b1; req_wr = 1'b0; req_size = 2'd2; req_addr = 32'h18; req_unsigned = 1'b0;
        @(posedge clk); #1;
        req_vld = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("ldrst_resp_vld", resp_vld, 0);
        check("ldrst_req_rdy", req_rdy, 1);
        check("ldrst_mem_en", mem_en, 0);
        check("ldrst_resp_rdata", resp_rdata, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        issue(200, '{32'h18, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, 32'h6, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0, 2});

        begin
            int n = 0;
            while (sb.size() != 0 && n < 50) begin
                @(posedge clk); n++;
            end
        end
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
